topob_pack: RTL

- Packs one top-of-book record (instrument, bid/ask price and size, timestamp) into the two-beat 64-bit word stream that topob_unpack consumes.
- Sits on the transmit/loopback side of the TOB path, between the book/strategy stage and the 64-bit link or replay FIFO.
- Accepts records on a valid/ready handshake and emits word0 then word1 on a valid/ready/last stream. It holds one record internally and sustains one record per two cycles.

---
 rtl/topob_pack_pkg.sv | 53 +++++
 rtl/topob_pack.sv | 115 +++++++++++
 2 files changed

// File: rtl/topob_pack_pkg.sv
// Shared top-of-book word layout: field widths, bit offsets inside the two 64-bit beats,
// FSM state encoding and the record payload held between word0 and word1.
// topob_pack and topob_unpack both take their layout from this package.
package topob_pack_pkg;

  localparam int INST_ID_W = 16;
  localparam int PRICE_W   = 32;
  localparam int SIZE_W    = 16;
  localparam int TS_W      = 64;
  localparam int EXT_W     = 16;

  // Field offsets inside word0 / word1
  localparam int TOB_W0_INST_LSB  = 0;
  localparam int TOB_W0_BIDPX_LSB = 16;
  localparam int TOB_W0_BIDSZ_LSB = 48;
  localparam int TOB_W1_ASKPX_LSB = 0;
  localparam int TOB_W1_ASKSZ_LSB = 32;
  localparam int TOB_W1_EXT_LSB   = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2
  } state_t;

  // Only the word1 payload needs holding; word0 goes straight into the output register.
  typedef struct packed {
    logic [EXT_W-1:0]   ext;
    logic [SIZE_W-1:0]  ask_sz;
    logic [PRICE_W-1:0] ask_px;
  } w1_hold_t;

  function automatic logic [63:0] tob_word0(input logic [INST_ID_W-1:0] inst,
                                            input logic [PRICE_W-1:0]   bid_px,
                                            input logic [SIZE_W-1:0]    bid_sz);
    logic [63:0] w;
    w = '0;
    w[TOB_W0_INST_LSB  +: INST_ID_W] = inst;
    w[TOB_W0_BIDPX_LSB +: PRICE_W]   = bid_px;
    w[TOB_W0_BIDSZ_LSB +: SIZE_W]    = bid_sz;
    return w;
  endfunction

  function automatic logic [63:0] tob_word1(input w1_hold_t h);
    logic [63:0] w;
    w = '0;
    w[TOB_W1_ASKPX_LSB +: PRICE_W] = h.ask_px;
    w[TOB_W1_ASKSZ_LSB +: SIZE_W]  = h.ask_sz;
    w[TOB_W1_EXT_LSB   +: EXT_W]   = h.ext;
    return w;
  endfunction

endpackage

// File: rtl/topob_pack.sv
// Packs one top-of-book record into a two-beat 64-bit stream (word0, then word1 with last).
// Latency: input handshake at N -> word0 valid at N+1 -> word1 at N+2; 1 record / 2 cycles.
// Backpressure: outputs hold while out_ready is low; in_ready low in W0, follows out_ready in W1.
// Optional macro TOPOB_PACK_TS_EN: word1[63:48] carries in_ts[15:0]; otherwise zero.
module topob_pack
  import topob_pack_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INST_ID_W-1:0] in_inst_id,
  input  logic [PRICE_W-1:0]   in_bid_px,
  input  logic [SIZE_W-1:0]    in_bid_sz,
  input  logic [PRICE_W-1:0]   in_ask_px,
  input  logic [SIZE_W-1:0]    in_ask_sz,
  input  logic [TS_W-1:0]      in_ts,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     rec_cnt
);

  state_t           state_q;
  w1_hold_t         hold_q;
  w1_hold_t         hold_d;
  logic             out_valid_q;
  logic             out_last_q;
  logic [63:0]      out_data_q;
  logic [63:0]      word0_d;
  logic [CNT_W-1:0] rec_cnt_q;
  logic [CNT_W-1:0] rec_cnt_d;
  logic             live_q;      // low until the first clock after reset release
  logic [EXT_W-1:0] ext_d;

`ifdef TOPOB_PACK_TS_EN
  logic unused_ts_hi;
  assign ext_d        = in_ts[EXT_W-1:0];
  assign unused_ts_hi = ^in_ts[TS_W-1:EXT_W];
`else
  logic unused_ts;
  assign ext_d     = '0;
  assign unused_ts = ^in_ts;
`endif

  assign hold_d    = '{ext: ext_d, ask_sz: in_ask_sz, ask_px: in_ask_px};
  assign word0_d   = tob_word0(in_inst_id, in_bid_px, in_bid_sz);
  assign rec_cnt_d = rec_cnt_q + CNT_W'(1);

  // Accept in IDLE, or in W1 when word1 leaves this cycle so the next record follows with no bubble.
  assign in_ready = ((state_q == ST_IDLE) && live_q) || ((state_q == ST_W1) && out_ready);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign rec_cnt   = rec_cnt_q;

  // Beat sequencer: capture record, present word0, then word1, count completed records.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      rec_cnt_q   <= '0;
      live_q      <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (in_valid && live_q) begin
            hold_q      <= hold_d;
            out_data_q  <= word0_d;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            state_q     <= ST_W0;
          end
        end
        ST_W0: begin
          if (out_ready) begin
            out_data_q <= tob_word1(hold_q);
            out_last_q <= 1'b1;
            state_q    <= ST_W1;
          end
        end
        ST_W1: begin
          if (out_ready) begin
            rec_cnt_q <= rec_cnt_d;
            if (in_valid) begin
              hold_q      <= hold_d;
              out_data_q  <= word0_d;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              state_q     <= ST_W0;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
